// File: rtl/decode_regfile_pkg.sv
// Shared Y86-64 decode constants and types for the decode/writeback slice.
package decode_regfile_pkg;

   localparam int unsigned REG_IDX_W = 4;

   localparam logic [REG_IDX_W-1:0] RNONE = 4'hF;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] ICMOVQ  = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   typedef struct packed {
      logic [REG_IDX_W-1:0] src_a;
      logic [REG_IDX_W-1:0] src_b;
      logic [REG_IDX_W-1:0] dst_e;
      logic [REG_IDX_W-1:0] dst_m;
   } dec_spec_t;

endpackage

// File: rtl/decode_regfile_scoreboard.sv
// In-flight writer counters per register, operand/destination stall and sticky underflow error.
module reg_scoreboard
   import decode_regfile_pkg::*;
#(
   parameter int unsigned NREG  = 15,
   parameter int unsigned CNT_W = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 issue,
   input  logic [REG_IDX_W-1:0] src_a,
   input  logic [REG_IDX_W-1:0] src_b,
   input  logic [REG_IDX_W-1:0] dst_e,
   input  logic [REG_IDX_W-1:0] dst_m,
   input  logic                 wb_en,
   input  logic [REG_IDX_W-1:0] wb_dst_e,
   input  logic [REG_IDX_W-1:0] wb_dst_m,
   output logic                 stall_c,
   output logic                 err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q [NREG];
   logic [NREG-1:0]  inc_c;
   logic [NREG-1:0]  dec_c;
   logic             underflow_c;
   logic             err_q;

   // A source waiting on exactly one writer is released when that writer retires this cycle.
   always_comb begin : hazard
      logic wb_hit;
      logic src_hit;
      logic dst_hit;
      stall_c = 1'b0;
      wb_hit  = 1'b0;
      src_hit = 1'b0;
      dst_hit = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         wb_hit  = wb_en && (wb_dst_e == REG_IDX_W'(i) || wb_dst_m == REG_IDX_W'(i));
         src_hit = (src_a == REG_IDX_W'(i)) || (src_b == REG_IDX_W'(i));
         dst_hit = (dst_e == REG_IDX_W'(i)) || (dst_m == REG_IDX_W'(i));
         if (src_hit && cnt_q[i] != '0 && !(cnt_q[i] == CNT_ONE && wb_hit))
            stall_c = 1'b1;
         if (dst_hit && cnt_q[i] == CNT_MAX)
            stall_c = 1'b1;
      end
   end

   always_comb begin : update
      inc_c       = '0;
      dec_c       = '0;
      underflow_c = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         inc_c[i] = issue && !stall_c && (dst_e == REG_IDX_W'(i) || dst_m == REG_IDX_W'(i));
         dec_c[i] = wb_en && (wb_dst_e == REG_IDX_W'(i) || wb_dst_m == REG_IDX_W'(i));
         if (dec_c[i] && !inc_c[i] && cnt_q[i] == '0)
            underflow_c = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NREG; i++)
            cnt_q[i] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (inc_c[i] && !dec_c[i])
               cnt_q[i] <= cnt_q[i] + CNT_ONE;
            else if (dec_c[i] && !inc_c[i] && cnt_q[i] != '0)
               cnt_q[i] <= cnt_q[i] - CNT_ONE;
         end
         err_q <= err_q | underflow_c;
      end
   end

   assign err = err_q;

endmodule

// File: rtl/decode_regfile.sv
// Y86-64 decode stage: specifier decode, register file with write-first bypass, and hazard stall.
module decode_regfile
   import decode_regfile_pkg::*;
#(
   parameter int unsigned          DATA_W    = 64,
   parameter int unsigned          NREG      = 15,
   parameter logic [REG_IDX_W-1:0] RSP_ID    = 4'd4,
   parameter int unsigned          CNT_W     = 2,
   parameter int unsigned          INIT_MODE = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [3:0]           icode_i,
   input  logic [REG_IDX_W-1:0] rA_i,
   input  logic [REG_IDX_W-1:0] rB_i,
   input  logic                 issue_i,
   input  logic                 wb_en_i,
   input  logic [REG_IDX_W-1:0] wb_dstE_i,
   input  logic [REG_IDX_W-1:0] wb_dstM_i,
   input  logic [DATA_W-1:0]    wb_valE_i,
   input  logic [DATA_W-1:0]    wb_valM_i,
   output logic [REG_IDX_W-1:0] srcA_o,
   output logic [REG_IDX_W-1:0] srcB_o,
   output logic [REG_IDX_W-1:0] dstE_o,
   output logic [REG_IDX_W-1:0] dstM_o,
   output logic [DATA_W-1:0]    valA_o,
   output logic [DATA_W-1:0]    valB_o,
   output logic                 stall_o,
   output logic                 err_o
);

   dec_spec_t        spec_c;
   logic [DATA_W-1:0] rf_q [NREG];

   always_comb begin : decode
      spec_c = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
      case (icode_i)
         ICMOVQ:  begin spec_c.src_a = rA_i;   spec_c.dst_e = rB_i; end
         IIRMOVQ: spec_c.dst_e = rB_i;
         IRMMOVQ: begin spec_c.src_a = rA_i;   spec_c.src_b = rB_i; end
         IMRMOVQ: begin spec_c.src_b = rB_i;   spec_c.dst_m = rA_i; end
         IOPQ:    begin spec_c.src_a = rA_i;   spec_c.src_b = rB_i; spec_c.dst_e = rB_i; end
         ICALL:   begin spec_c.src_b = RSP_ID; spec_c.dst_e = RSP_ID; end
         IRET:    begin spec_c.src_a = RSP_ID; spec_c.src_b = RSP_ID; spec_c.dst_e = RSP_ID; end
         IPUSHQ:  begin spec_c.src_a = rA_i;   spec_c.src_b = RSP_ID; spec_c.dst_e = RSP_ID; end
         IPOPQ:   begin
            spec_c.src_a = RSP_ID;
            spec_c.src_b = RSP_ID;
            spec_c.dst_e = RSP_ID;
            spec_c.dst_m = rA_i;
         end
         default: ;
      endcase
   end

   assign srcA_o = spec_c.src_a;
   assign srcB_o = spec_c.src_b;
   assign dstE_o = spec_c.dst_e;
   assign dstM_o = spec_c.dst_m;

   // Bypass priority matches write order: valM beats valE beats stored contents.
   always_comb begin : operand_read
      valA_o = '0;
      valB_o = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (spec_c.src_a == REG_IDX_W'(i)) valA_o = rf_q[i];
         if (spec_c.src_b == REG_IDX_W'(i)) valB_o = rf_q[i];
      end
      for (int unsigned i = 0; i < NREG; i++) begin
         if (wb_en_i && spec_c.src_a == REG_IDX_W'(i)) begin
            if (wb_dstM_i == REG_IDX_W'(i))      valA_o = wb_valM_i;
            else if (wb_dstE_i == REG_IDX_W'(i)) valA_o = wb_valE_i;
         end
         if (wb_en_i && spec_c.src_b == REG_IDX_W'(i)) begin
            if (wb_dstM_i == REG_IDX_W'(i))      valB_o = wb_valM_i;
            else if (wb_dstE_i == REG_IDX_W'(i)) valB_o = wb_valE_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NREG; i++)
            rf_q[i] <= (INIT_MODE == 1) ? DATA_W'(i) : '0;
      end else if (wb_en_i) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            if (wb_dstM_i == REG_IDX_W'(i))      rf_q[i] <= wb_valM_i;
            else if (wb_dstE_i == REG_IDX_W'(i)) rf_q[i] <= wb_valE_i;
         end
      end
   end

   reg_scoreboard #(
      .NREG  (NREG),
      .CNT_W (CNT_W)
   ) u_scoreboard (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .issue    (issue_i),
      .src_a    (spec_c.src_a),
      .src_b    (spec_c.src_b),
      .dst_e    (spec_c.dst_e),
      .dst_m    (spec_c.dst_m),
      .wb_en    (wb_en_i),
      .wb_dst_e (wb_dstE_i),
      .wb_dst_m (wb_dstM_i),
      .stall_c  (stall_o),
      .err      (err_o)
   );

endmodule

// File: tb/tb_decode_regfile.sv
// Directed bench for decode_regfile: decode table, bypass, stall, scoreboard and reset corners.
module tb_decode_regfile;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  icode_i, rA_i, rB_i;
   logic        issue_i, wb_en_i;
   logic [3:0]  wb_dstE_i, wb_dstM_i;
   logic [63:0] wb_valE_i, wb_valM_i;
   logic [3:0]  srcA_o, srcB_o, dstE_o, dstM_o;
   logic [63:0] valA_o, valB_o;
   logic        stall_o, err_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   decode_regfile #(
      .DATA_W(64), .NREG(15), .RSP_ID(4'd4), .CNT_W(2), .INIT_MODE(1)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
      .issue_i(issue_i), .wb_en_i(wb_en_i), .wb_dstE_i(wb_dstE_i), .wb_dstM_i(wb_dstM_i),
      .wb_valE_i(wb_valE_i), .wb_valM_i(wb_valM_i), .srcA_o(srcA_o), .srcB_o(srcB_o),
      .dstE_o(dstE_o), .dstM_o(dstM_o), .valA_o(valA_o), .valB_o(valB_o),
      .stall_o(stall_o), .err_o(err_o)
   );

   typedef struct {
      logic [3:0]  icode, ra, rb;
      logic [3:0]  e_srca, e_srcb, e_dste, e_dstm;
      logic [63:0] e_vala, e_valb;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic iss, input logic wbe, input logic [3:0] wde,
                        input logic [3:0] wdm, input logic [63:0] ve, input logic [63:0] vm);
      icode_i = ic; rA_i = ra; rB_i = rb; issue_i = iss; wb_en_i = wbe;
      wb_dstE_i = wde; wb_dstM_i = wdm; wb_valE_i = ve; wb_valM_i = vm;
   endtask

   task automatic idle();
      drive(4'h1, 4'hF, 4'hF, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
   endtask

   // Advance one rising edge, then return to the falling edge for the next drive.
   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   initial begin
      // icode, rA, rB, srcA, srcB, dstE, dstM, valA, valB  (init contents: r[i] = i)
      vecs[0]  = '{4'h6, 4'h2, 4'h3, 4'h2, 4'h3, 4'h3, 4'hF, 64'd2,  64'd3};
      vecs[1]  = '{4'h2, 4'h2, 4'h3, 4'h2, 4'hF, 4'h3, 4'hF, 64'd2,  64'd0};
      vecs[2]  = '{4'h3, 4'h2, 4'h3, 4'hF, 4'hF, 4'h3, 4'hF, 64'd0,  64'd0};
      vecs[3]  = '{4'h4, 4'h2, 4'h3, 4'h2, 4'h3, 4'hF, 4'hF, 64'd2,  64'd3};
      vecs[4]  = '{4'h5, 4'h2, 4'h3, 4'hF, 4'h3, 4'hF, 4'h2, 64'd0,  64'd3};
      vecs[5]  = '{4'hA, 4'h2, 4'h3, 4'h2, 4'h4, 4'h4, 4'hF, 64'd2,  64'd4};
      vecs[6]  = '{4'hB, 4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'h2, 64'd4,  64'd4};
      vecs[7]  = '{4'h8, 4'h2, 4'h3, 4'hF, 4'h4, 4'h4, 4'hF, 64'd0,  64'd4};
      vecs[8]  = '{4'h9, 4'h2, 4'h3, 4'h4, 4'h4, 4'h4, 4'hF, 64'd4,  64'd4};
      vecs[9]  = '{4'h7, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 64'd0,  64'd0};
      vecs[10] = '{4'h0, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 64'd0,  64'd0};
      vecs[11] = '{4'hC, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF, 4'hF, 64'd0,  64'd0};
      vecs[12] = '{4'h6, 4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hF, 64'd14, 64'd1};
      vecs[13] = '{4'h6, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 64'd0,  64'd0};

      rst_i = 1'b1;
      idle();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("reset_stall", 64'(stall_o), 64'd0);
      chk("reset_err", 64'(err_o), 64'd0);
      @(negedge clk_i);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].icode, vecs[i].ra, vecs[i].rb, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
         #1;
         chk($sformatf("v%0d_srcA", i), 64'(srcA_o), 64'(vecs[i].e_srca));
         chk($sformatf("v%0d_srcB", i), 64'(srcB_o), 64'(vecs[i].e_srcb));
         chk($sformatf("v%0d_dstE", i), 64'(dstE_o), 64'(vecs[i].e_dste));
         chk($sformatf("v%0d_dstM", i), 64'(dstM_o), 64'(vecs[i].e_dstm));
         chk($sformatf("v%0d_valA", i), valA_o, vecs[i].e_vala);
         chk($sformatf("v%0d_valB", i), valB_o, vecs[i].e_valb);
         chk($sformatf("v%0d_stall", i), 64'(stall_o), 64'd0);
         @(negedge clk_i);
      end

      // Same-cycle bypass: valM wins over valE on the same destination.
      drive(4'h6, 4'h5, 4'h0, 1'b0, 1'b1, 4'h5, 4'h5, 64'hAA, 64'hBB);
      #1;
      chk("bypass_valA", valA_o, 64'hBB);
      chk("bypass_valB", valB_o, 64'd0);
      step();
      drive(4'h6, 4'h5, 4'h0, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("written_valA", valA_o, 64'hBB);
      chk("wb_underflow_err", 64'(err_o), 64'd1);
      rst_i = 1'b1;
      #1;
      chk("reinit_valA", valA_o, 64'd5);
      chk("reinit_err", 64'(err_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // RAW on r6 from an issued irmovq.
      drive(4'h3, 4'hF, 4'h6, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("irmovq_stall", 64'(stall_o), 64'd0);
      step();
      drive(4'h6, 4'h6, 4'h1, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("raw_r6_stall", 64'(stall_o), 64'd1);
      drive(4'h6, 4'h6, 4'h1, 1'b0, 1'b1, 4'h6, 4'hF, 64'h1234, 64'd0);
      #1;
      chk("raw_r6_wb_stall", 64'(stall_o), 64'd0);
      chk("raw_r6_wb_valA", valA_o, 64'h1234);
      step();
      drive(4'h6, 4'h6, 4'h1, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r6_retired_stall", 64'(stall_o), 64'd0);
      chk("r6_retired_valA", valA_o, 64'h1234);
      chk("r6_err", 64'(err_o), 64'd0);

      // popq %rsp: both destinations on r4 count once.
      drive(4'hB, 4'h4, 4'hF, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("popq_stall", 64'(stall_o), 64'd0);
      step();
      drive(4'h6, 4'h4, 4'h1, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r4_pending_stall", 64'(stall_o), 64'd1);
      drive(4'h6, 4'h4, 4'h1, 1'b0, 1'b1, 4'h4, 4'h4, 64'h10, 64'h20);
      #1;
      chk("r4_wb_stall", 64'(stall_o), 64'd0);
      chk("r4_wb_valA", valA_o, 64'h20);
      step();
      drive(4'h6, 4'h4, 4'h1, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r4_done_stall", 64'(stall_o), 64'd0);
      chk("r4_done_valA", valA_o, 64'h20);
      chk("r4_done_err", 64'(err_o), 64'd0);

      // Saturate r7 at three in flight.
      for (int k = 0; k < 3; k++) begin
         drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
         #1;
         chk($sformatf("r7_issue%0d_stall", k), 64'(stall_o), 64'd0);
         step();
      end
      drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r7_sat_stall", 64'(stall_o), 64'd1);
      step();
      drive(4'h6, 4'h7, 4'h1, 1'b0, 1'b1, 4'h7, 4'hF, 64'h77, 64'd0);
      #1;
      chk("r7_cnt3_wb_src_stall", 64'(stall_o), 64'd1);
      step();
      drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b1, 4'h7, 4'hF, 64'h78, 64'd0);
      #1;
      chk("r7_issue_wb_stall", 64'(stall_o), 64'd0);
      step();
      drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r7_refill_stall", 64'(stall_o), 64'd0);
      step();
      drive(4'h3, 4'hF, 4'h7, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r7_resat_stall", 64'(stall_o), 64'd1);
      chk("r7_err", 64'(err_o), 64'd0);
      step();

      // Underflow on r9 is sticky; async reset clears it mid-cycle.
      drive(4'h1, 4'hF, 4'hF, 1'b0, 1'b1, 4'h9, 4'hF, 64'h99, 64'd0);
      step();
      idle();
      #1;
      chk("r9_err_set", 64'(err_o), 64'd1);
      step();
      drive(4'h3, 4'hF, 4'h8, 1'b1, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("err_sticky", 64'(err_o), 64'd1);
      step();
      drive(4'h6, 4'h8, 4'h7, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("r8_pending_stall", 64'(stall_o), 64'd1);
      #1;
      rst_i = 1'b1;
      #1;
      chk("async_rst_err", 64'(err_o), 64'd0);
      chk("async_rst_stall", 64'(stall_o), 64'd0);
      chk("async_rst_valA", valA_o, 64'd8);
      chk("async_rst_valB", valB_o, 64'd7);
      @(negedge clk_i);
      rst_i = 1'b0;
      drive(4'h6, 4'h6, 4'h4, 1'b0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0);
      #1;
      chk("post_rst_valA", valA_o, 64'd6);
      chk("post_rst_valB", valB_o, 64'd4);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
